// File: rtl/dac_softmute.sv
// Soft mute/fade stage between the mixer and the DAC serializer: forwards pop/ack
// with one register of latency and scales each acked sample by a linear Q1.15 gain.
module dac_softmute #(
    parameter int unsigned GAIN_STEP = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mute_i,
    input  logic [1:0]  pop_i,
    output logic [1:0]  pop_o,
    input  logic [1:0]  ack_i,
    input  logic [23:0] data_i,
    output logic [1:0]  ack_o,
    output logic [23:0] data_o,
    output logic        muted_o,
    output logic        ramping_o
);

    localparam logic [1:0] ST_MUTED     = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_PLAY      = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    localparam logic [15:0] GAIN_UNITY = 16'h8000;
    localparam logic [16:0] STEP       = GAIN_STEP[16:0];

    logic [1:0]  state_q, state_d;
    logic [15:0] gain_q, gain_d;
    logic [1:0]  pop_q, ack_q;
    logic [23:0] data_q;
    logic        muted_q, ramping_q;

    logic [16:0] gain_up;
    logic [15:0] gain_dn;
    logic        frame_tick;

    assign frame_tick = ack_i[1];
    assign gain_up    = {1'b0, gain_q} + STEP;
    assign gain_dn    = gain_q - STEP[15:0];

    // Ramps step once per tick in either direction, so a reversal continues
    // from the current gain instead of jumping.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (frame_tick) begin
            case (state_q)
                ST_MUTED: begin
                    if (!mute_i) begin
                        state_d = ST_RAMP_UP;
                        gain_d  = STEP[15:0];
                    end
                end
                ST_PLAY: begin
                    if (mute_i) begin
                        state_d = ST_RAMP_DOWN;
                        gain_d  = gain_dn;
                    end
                end
                default: begin
                    if (!mute_i) begin
                        if (gain_up >= {1'b0, GAIN_UNITY}) begin
                            state_d = ST_PLAY;
                            gain_d  = GAIN_UNITY;
                        end else begin
                            state_d = ST_RAMP_UP;
                            gain_d  = gain_up[15:0];
                        end
                    end else begin
                        if ({1'b0, gain_q} <= STEP) begin
                            state_d = ST_MUTED;
                            gain_d  = 16'd0;
                        end else begin
                            state_d = ST_RAMP_DOWN;
                            gain_d  = gain_dn;
                        end
                    end
                end
            endcase
        end
    end

    // Gain <= 1.0, so bits [38:15] always hold the full floor-shifted result.
    logic signed [41:0] product;
    logic               unused_product;
    assign product        = $signed(data_i) * $signed({2'b00, gain_q});
    assign unused_product = ^{product[41:39], product[14:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_MUTED;
            gain_q    <= 16'd0;
            pop_q     <= 2'b00;
            ack_q     <= 2'b00;
            data_q    <= 24'd0;
            muted_q   <= 1'b1;
            ramping_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gain_q    <= gain_d;
            pop_q     <= pop_i;
            ack_q     <= ack_i;
            data_q    <= product[38:15];
            muted_q   <= (state_d == ST_MUTED);
            ramping_q <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
        end
    end

    assign pop_o     = pop_q;
    assign ack_o     = ack_q;
    assign data_o    = data_q;
    assign muted_o   = muted_q;
    assign ramping_o = ramping_q;

endmodule

// File: tb/tb_dac_softmute.sv
// Scoreboard bench for dac_softmute: every driven cycle queues its expected
// outputs, which are popped and compared one cycle later.
module tb_dac_softmute;

    logic        clk;
    logic        rst;
    logic        mute_i;
    logic [1:0]  pop_i;
    logic [1:0]  pop_o;
    logic [1:0]  ack_i;
    logic [23:0] data_i;
    logic [1:0]  ack_o;
    logic [23:0] data_o;
    logic        muted_o;
    logic        ramping_o;

    dac_softmute #(.GAIN_STEP(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .mute_i    (mute_i),
        .pop_i     (pop_i),
        .pop_o     (pop_o),
        .ack_i     (ack_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .data_o    (data_o),
        .muted_o   (muted_o),
        .ramping_o (ramping_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pop;
        logic [1:0]  ack;
        logic [23:0] data;
    } exp_t;

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Reference model: 0 MUTED, 1 RAMP_UP, 2 PLAY, 3 RAMP_DOWN
    int   m_state = 0;
    int   m_gain  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] scale(input logic [23:0] d, input int g);
        longint p;
        longint q;
        logic [63:0] r;
        p = longint'($signed(d)) * longint'(g);
        q = p >>> 15;
        r = q;
        return r[23:0];
    endfunction

    task automatic model_tick();
        case (m_state)
            0: if (!mute_i) begin m_state = 1; m_gain = 128; end
            2: if (mute_i) begin m_state = 3; m_gain = m_gain - 128; end
            default: begin
                if (!mute_i) begin
                    m_gain = m_gain + 128;
                    if (m_gain >= 32768) begin m_gain = 32768; m_state = 2; end
                    else m_state = 1;
                end else if (m_gain <= 128) begin
                    m_gain = 0; m_state = 0;
                end else begin
                    m_gain = m_gain - 128; m_state = 3;
                end
            end
        endcase
    endtask

    task automatic cyc(input logic [1:0] ack, input logic [23:0] d, output logic [23:0] obs);
        exp_t e;
        @(negedge clk);
        pop_i  = 2'($urandom_range(0, 3));
        ack_i  = ack;
        data_i = d;
        e.pop  = pop_i;
        e.ack  = ack;
        e.data = scale(d, m_gain);
        sb.push_back(e);
        @(posedge clk);
        if (ack[1]) model_tick();
        #1;
        e = sb.pop_front();
        chk("pop_o", 32'(pop_o), 32'(e.pop));
        chk("ack_o", 32'(ack_o), 32'(e.ack));
        if (e.ack != 2'b00) chk("data_o", 32'(data_o), 32'(e.data));
        chk("muted_o", 32'(muted_o), 32'(m_state == 0));
        chk("ramping_o", 32'(ramping_o), 32'(m_state == 1 || m_state == 3));
        obs = data_o;
    endtask

    task automatic frame(input logic [23:0] l, input logic [23:0] r,
                         output logic [23:0] ol, output logic [23:0] orr);
        cyc(2'b01, l, ol);
        cyc(2'b10, r, orr);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        ack_i = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_state = 0;
        m_gain  = 0;
    endtask

    logic [23:0] ol, orr;
    int          g, g_prev, delta;

    initial begin
        rst    = 1'b0;
        mute_i = 1'b1;
        pop_i  = 2'b11;
        ack_i  = 2'b01;
        data_i = 24'h123456;

        // Reset held with activity on the inputs
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_pop", 32'(pop_o), 32'h0);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_muted", 32'(muted_o), 32'h1);
        chk("rst_ramping", 32'(ramping_o), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            frame(24'($urandom), 24'($urandom), ol, orr);
            chk("muted_l", 32'(ol), 32'h0);
            chk("muted_r", 32'(orr), 32'h0);
        end

        // Truncation at gain 128
        mute_i = 1'b0;
        frame(24'h123456, 24'h123456, ol, orr);
        frame(24'hFFFFFF, 24'h000001, ol, orr);
        chk("trunc_neg1", 32'(ol), 32'h00FFFFFF);
        chk("trunc_pos1", 32'(orr), 32'h0);
        mute_i = 1'b1;
        for (int i = 0; i < 3; i++) frame(24'h0, 24'h0, ol, orr);
        chk("remuted", 32'(muted_o), 32'h1);

        // Fade-in from MUTED
        mute_i = 1'b0;
        frame(24'h400000, 24'h400000, ol, orr);
        for (int k = 1; k <= 260; k++) begin
            cyc(2'b01, 24'h400000, ol);
            chk("fade_l", 32'(ol), (k <= 256) ? 32'(k * 32'h4000) : 32'h400000);
            chk("fade_ramp", 32'(ramping_o), 32'(k <= 255));
            cyc(2'b10, 24'h400000, orr);
        end

        // Bit-exact passthrough in PLAY
        frame(24'h800000, 24'h7FFFFF, ol, orr);
        chk("pass_min", 32'(ol), 32'h800000);
        chk("pass_max", 32'(orr), 32'h7FFFFF);
        frame(24'h000001, 24'hABCDEF, ol, orr);
        chk("pass_one", 32'(ol), 32'h000001);
        chk("pass_any", 32'(orr), 32'hABCDEF);

        // Reversal: 100 frames down, then 100 frames up
        g_prev = 32768;
        mute_i = 1'b1;
        for (int j = 0; j < 100; j++) begin
            frame(24'h400000, 24'h400000, ol, orr);
            g = int'(ol) >> 7;
            delta = (g > g_prev) ? g - g_prev : g_prev - g;
            chk("rev_step_dn", 32'(delta <= 128), 32'h1);
            g_prev = g;
        end
        mute_i = 1'b0;
        for (int j = 0; j <= 100; j++) begin
            frame(24'h400000, 24'h400000, ol, orr);
            g = int'(ol) >> 7;
            if (j == 0) chk("rev_bottom", 32'(ol), 32'(19968 * 128));
            delta = (g > g_prev) ? g - g_prev : g_prev - g;
            chk("rev_step_up", 32'(delta <= 128), 32'h1);
            g_prev = g;
        end
        chk("rev_top", 32'(ol), 32'h400000);

        // Async reset in the middle of a fade-in sample
        mute_i = 1'b1;
        reset_pulse();
        mute_i = 1'b0;
        for (int k = 0; k < 50; k++) frame(24'h400000, 24'h400000, ol, orr);
        @(negedge clk);
        ack_i  = 2'b01;
        data_i = 24'h400000;
        @(posedge clk);
        #2;
        chk("mid_ack", 32'(ack_o), 32'h1);
        chk("mid_data", 32'(data_o), 32'(50 * 32'h4000));
        rst = 1'b0;
        #1;
        chk("async_ack", 32'(ack_o), 32'h0);
        chk("async_data", 32'(data_o), 32'h0);
        chk("async_muted", 32'(muted_o), 32'h1);
        ack_i = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_state = 0;
        m_gain  = 0;
        frame(24'h400000, 24'h400000, ol, orr);
        chk("restart_f0", 32'(ol), 32'h0);
        frame(24'h400000, 24'h400000, ol, orr);
        chk("restart_f1", 32'(ol), 32'h4000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
